// File: rtl/i2c_pkg.sv
// Shared constants for the I2C slave receiver: state encoding,
// ACK/NACK bus levels and address width.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_WR   = 1'b0;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    ADDR     = ST_ADDR,
    ADDR_ACK = ST_ADDR_ACK,
    DATA     = ST_DATA,
    DATA_ACK = ST_DATA_ACK,
    IGNORE   = ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_slave_rx_line_sync.sv
// Two-flop synchronizer plus edge pulses for one I2C line.
// Optional 3-sample majority filter: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= line_i;
      s2_q <= s1_q;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] h_q;
  logic       f_q, p_q, maj;

  // any single-sample excursion is outvoted by its two neighbours
  assign maj = (s2_q & h_q[0]) | (s2_q & h_q[1]) | (h_q[0] & h_q[1]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q <= 2'b11;
      f_q <= 1'b1;
      p_q <= 1'b1;
    end else begin
      h_q <= {h_q[0], s2_q};
      f_q <= maj;
      p_q <= f_q;
    end
  end

  assign level_o = f_q;
  assign rise_o  = f_q & ~p_q;
  assign fall_o  = ~f_q & p_q;
`else
  logic d_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) d_q <= 1'b1;
    else         d_q <= s2_q;
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~d_q;
  assign fall_o  = ~s2_q & d_q;
`endif

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver with per-byte ACK/NACK and byte counter.
// Glitch filter on the line synchronizers: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR   = 7'h50,
  parameter int unsigned           BYTE_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  input  logic                  sda_in,
  input  logic                  rx_ready,
  output logic                  sda_oe,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  output logic                  addr_match,
  output logic                  busy,
  output logic                  start_det,
  output logic                  stop_det,
  output logic [BYTE_CNT_W-1:0] byte_cnt
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl (
    .clk_i  (clk),
    .rst_ni (reset),
    .line_i (scl),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync u_sda (
    .clk_i  (clk),
    .rst_ni (reset),
    .line_i (sda_in),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e            state_q, state_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  oe_q, oe_d;
  logic                  valid_q, valid_d;
  logic                  am_q, am_d;
  logic                  busy_q, busy_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      am_q    <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      am_q    <= am_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    oe_d    = oe_q;
    valid_d = 1'b0;
    am_d    = am_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    cnt_d   = cnt_q;
    // bus conditions win over any scl edge seen in the same cycle
    if (scl_lvl && sda_fall) begin
      start_d = 1'b1;
      busy_d  = 1'b1;
      am_d    = 1'b0;
      oe_d    = 1'b0;
      bit_d   = '0;
      cnt_d   = '0;
      state_d = ADDR;
    end else if (scl_lvl && sda_rise) begin
      stop_d  = 1'b1;
      busy_d  = 1'b0;
      am_d    = 1'b0;
      oe_d    = 1'b0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        ADDR, DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7 && state_q == ADDR) begin
              if (shift_d[7:1] == DEV_ADDR && shift_d[0] == I2C_WR)
                state_d = ADDR_ACK;
              else
                state_d = IGNORE;
            end else if (bit_q == 3'd7) begin
              data_d = shift_d;
              if (rx_ready) begin
                valid_d = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + BYTE_CNT_W'(1);
                state_d = DATA_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // first fall drives ACK, second fall releases it
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
              if (state_q == ADDR_ACK) am_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              bit_d   = '0;
              state_d = DATA;
            end
          end
        end
        IGNORE:  oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe     = oe_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign addr_match = am_q;
  assign busy       = busy_q;
  assign start_det  = start_q;
  assign stop_det   = stop_q;
  assign byte_cnt   = cnt_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Randomized bench for i2c_slave_rx against a transaction-level model.
// Glitch case runs only with I2C_SLAVE_GLITCH_FILTER_EN.
module tb_i2c_slave_rx;

  localparam int Q = 8;
  localparam logic [6:0] DEV = 7'h50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] data_out;
  logic       data_valid;
  logic       addr_match;
  logic       busy;
  logic       start_det;
  logic       stop_det;
  logic [7:0] byte_cnt;

  // open-drain wire: master releases high, slave may pull low
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_rx dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_in),
    .rx_ready  (rx_ready),
    .sda_oe    (sda_oe),
    .data_out  (data_out),
    .data_valid(data_valid),
    .addr_match(addr_match),
    .busy      (busy),
    .start_det (start_det),
    .stop_det  (stop_det),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;
  int n_stop = 0;
  int n_valid = 0;
  int e_start = 0;
  int e_stop = 0;
  int e_valid = 0;
  logic [7:0] e_data = 8'h00;

  logic [7:0] d_a[8];
  logic       r_a[8];

  always @(posedge clk) begin
    if (start_det)  n_start++;
    if (stop_det)   n_stop++;
    if (data_valid) n_valid++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    tick(Q);
    scl = 1'b1;
    tick(2 * Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic ack,
                           output logic am);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    ack = sda_oe;
    am  = addr_match;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic do_start();
    if (scl == 1'b0) begin
      sda_m = 1'b1;
      tick(Q);
      scl = 1'b1;
    end
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(2 * Q);
  endtask

  task automatic end_checks(input int cnt);
    check("busy_end", busy, 0);
    check("addr_match_end", addr_match, 0);
    check("byte_cnt", byte_cnt, cnt);
    check("data_out", data_out, e_data);
    check("n_valid", n_valid, e_valid);
    check("n_start", n_start, e_start);
    check("n_stop", n_stop, e_stop);
  endtask

  // model: a write to DEV is ACKed; each data byte is captured while
  // accepting, ACKed iff rx_ready, and the first NACK ends acceptance
  task automatic run_xfer(input logic [7:0] addr, input int n,
                          input int cut);
    logic ack, am, match, acc;
    int   cnt;
    match = (addr[7:1] == DEV) && !addr[0];
    do_start();
    e_start++;
    send_byte(addr, ack, am);
    check("addr_ack", ack, match);
    check("addr_match", am, match);
    check("busy_mid", busy, 1);
    acc = match;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      rx_ready = r_a[i];
      send_byte(d_a[i], ack, am);
      check("data_ack", ack, acc && r_a[i]);
      if (acc) begin
        e_data = d_a[i];
        if (r_a[i]) begin
          if (cnt < 255) cnt++;
          e_valid++;
        end else begin
          acc = 1'b0;
        end
      end
    end
    if (cut > 0) begin
      for (int i = 0; i < cut; i++) send_bit(1'($urandom_range(0, 1)));
    end else begin
      do_stop();
      e_stop++;
      end_checks(cnt);
    end
  endtask

  initial begin
    logic ack, am;
    logic [7:0] a;
    int n;
    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_addr_match", addr_match, 0);
    check("rst_valid", data_valid, 0);
    reset = 1'b1;
    tick(4);

    d_a[0] = 8'h3C; r_a[0] = 1'b1;
    run_xfer(8'hA0, 1, 0);

    for (int i = 0; i < 3; i++) begin
      d_a[i] = 8'($urandom);
      r_a[i] = 1'b1;
    end
    run_xfer(8'hA2, 3, 0);
    run_xfer(8'hA1, 2, 0);

    d_a[0] = 8'h11; r_a[0] = 1'b1;
    d_a[1] = 8'h22; r_a[1] = 1'b1;
    d_a[2] = 8'h33; r_a[2] = 1'b0;
    run_xfer(8'hA0, 3, 0);

    d_a[0] = 8'h9A; r_a[0] = 1'b1;
    run_xfer(8'hA0, 1, 4);
    d_a[0] = 8'h55; r_a[0] = 1'b1;
    run_xfer(8'hA0, 1, 0);

    // reset while the slave is holding the address ACK
    do_start();
    e_start++;
    for (int i = 7; i >= 0; i--) send_bit(a_const(i));
    sda_m = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    check("oe_mid_ack", sda_oe, 1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("rst_oe_mid", sda_oe, 0);
    check("rst_busy_mid", busy, 0);
    check("rst_cnt_mid", byte_cnt, 0);
    e_data = 8'h00;
    tick(Q);
    scl = 1'b0;
    tick(Q);
    do_stop();
    e_stop++;
    d_a[0] = 8'h7E; r_a[0] = 1'b1;
    run_xfer(8'hA0, 1, 0);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    tick(Q);
    @(posedge clk);
    sda_m = 1'b0;
    @(posedge clk);
    sda_m = 1'b1;
    tick(3 * Q);
    check("glitch_start", n_start, e_start);
    check("glitch_busy", busy, 0);
`endif

    for (int t = 0; t < 18; t++) begin
      case ($urandom_range(0, 5))
        3:       a = 8'hA1;
        4:       a = 8'hA2;
        5:       a = 8'($urandom);
        default: a = 8'hA0;
      endcase
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        d_a[i] = 8'($urandom);
        r_a[i] = ($urandom_range(0, 3) != 0);
      end
      run_xfer(a, n, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0);
    end
    run_xfer(8'hA0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  function automatic logic a_const(input int i);
    logic [7:0] v;
    v = 8'hA0;
    return v[i];
  endfunction

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Write-only I2C slave receiver that sits directly downstream of the i2c_master block, on the SCL/SDA bus lines that block drives.
- Oversamples SCL/SDA on the fast system clock.
- Detects START, repeated START and STOP; shifts in the address byte; ACKs a matching write address.
- Receives data bytes MSB-first, ACKs or NACKs each one, and presents each byte on a parallel port with a one-cycle valid pulse.

Parameters:
- DEV_ADDR, 7'h50, 7-bit slave address this block answers to.
- BYTE_CNT_W, 8, width of the saturating received-byte counter.

Ports:
- clk  in  1  system clock; must be at least 8x SCL frequency.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- scl  in  1  bus clock from master.
- sda_in  in  1  bus data as seen on the wire.
- rx_ready  in  1  consumer can accept a byte; sampled at the 8th data bit; 0 -> NACK.
- sda_oe  out  1  1 = pull SDA low (open-drain ACK drive); 0 = release.
- data_out  out  8  last received data byte.
- data_valid  out  1  one-clk pulse when data_out updates.
- addr_match  out  1  high from a matching address ACK until STOP/START.
- busy  out  1  high from START until STOP.
- start_det  out  1  one-clk pulse on START or repeated START.
- stop_det  out  1  one-clk pulse on STOP.
- byte_cnt  out  BYTE_CNT_W  data bytes accepted this transaction; saturates at all-ones.

Behaviour:
- Reset (reset==0 at posedge clk):
  - sda_oe=0, data_out=8'h00, data_valid=0, addr_match=0, busy=0, start_det=0, stop_det=0, byte_cnt=0.
  - state=IDLE, bit counter=0, synchronizer flops=1.
- Input path:
  - scl and sda_in each pass through a 2-flop synchronizer.
  - A third flop stage yields scl_rise, scl_fall, sda_rise and sda_fall pulses.
  - Event latency from the wire is 3 clk.
- START: sda_fall while synced scl==1.
  - Valid in any state, including mid-byte; this is the repeated-START case.
  - start_det pulses, busy=1, addr_match=0, sda_oe=0, bit counter=0, byte_cnt=0, state=ADDR.
- STOP: sda_rise while synced scl==1.
  - Valid in any state; stop_det pulses, busy=0, addr_match=0, sda_oe=0, state=IDLE.
  - byte_cnt holds its value until the next START.
- Simultaneous events: START/STOP detection takes priority over any scl-edge action in the same cycle.
- Bit sampling: on scl_rise, shift synced sda into the shift register MSB-first and increment the bit counter.
- States:
  - IDLE: wait for START.
  - ADDR: after the 8th scl_rise, compare shift[7:1] with DEV_ADDR.
    - Match and shift[0]==0 (write): go to ADDR_ACK.
    - Otherwise (mismatch, or read request): go to IGNORE; SDA stays released, which the master sees as NACK.
  - ADDR_ACK:
    - On the next scl_fall: sda_oe=1, addr_match=1.
    - On the following scl_fall: sda_oe=0, bit counter=0, state=DATA.
  - DATA:
    - After the 8th scl_rise: data_out=shift, bit counter=0.
    - If rx_ready==1: data_valid pulses (1 clk after the sample edge), byte_cnt increments (saturating), state=DATA_ACK.
    - If rx_ready==0: data_out still updates, but no data_valid, no ACK; state=IGNORE.
  - DATA_ACK: same ACK drive timing as ADDR_ACK, then return to DATA.
  - IGNORE: sda_oe=0; only START/STOP are honoured.
- sda_oe changes only on scl_fall, or on START/STOP. It never changes while synced scl==1, except when released by STOP/START.
- A NACKed byte ends data acceptance until the next START.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: each synced line passes through a 3-sample majority filter before edge detection. Pulses shorter than 2 clk are rejected. Event latency becomes 5 clk.
- Undefined: no filter; event latency is 3 clk.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding localparams (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE);
  - I2C_ACK=0 and I2C_NACK=1;
  - the address width constant 7.
- One sub-module, i2c_line_sync: the 2-flop synchronizer, the optional glitch filter, and the rise/fall pulse generation. Instantiated once each for scl and sda_in.

Test Plan:
- START, byte 8'hA0 (addr 7'h50, write), byte 8'h3C, STOP, with rx_ready=1 -> sda_oe=1 across both 9th clocks; data_out=8'h3C; data_valid pulses once; byte_cnt=1; start_det and stop_det pulse once each; busy returns to 0.
- Address byte 8'hA2 (7'h51) -> IGNORE state; sda_oe never asserts; addr_match=0; no data_valid for three following bytes.
- Address 8'hA1 (7'h50, read) -> NACK; sda_oe=0 throughout; state=IGNORE until STOP.
- Write 8'h11, 8'h22 with rx_ready=1, then 8'h33 with rx_ready=0 -> first two bytes ACKed; third byte NACKed; data_out=8'h33; data_valid pulsed twice; byte_cnt=2.
- Repeated START after 4 bits of a data byte, then 8'hA0 and 8'h55 -> start_det pulses; byte_cnt resets to 0; 8'h55 received; byte_cnt=1.
- Drive reset=0 for 1 clk while sda_oe=1 mid-ACK -> next cycle sda_oe=0, busy=0, state=IDLE; a subsequent transfer of 8'hA0, 8'h7E completes normally.
- With I2C_SLAVE_GLITCH_FILTER_EN defined, inject a 1-clk SDA low pulse while SCL high -> no start_det, state unchanged.
